button_conditioner: RTL and testbench

//  Conditions raw push-button pins (BTNU, BTND, ...) before they reach the MMIO register file.
//  Per button: 2-flop synchroniser, debounce filter, one-cycle press pulse and sticky press flag.
//  The processor polls the debounced level or the sticky flag. Reading address 1000/1003 then never sees bounce.

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_channel.sv | 118 +++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel indices, default timing, counter sizing.
// Used by btn_channel and button_conditioner; optional auto-repeat is enabled with BTN_REPEAT_EN.
package btn_pkg;

    localparam int BTN_IDX_U = 0;
    localparam int BTN_IDX_D = 1;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat spacing at 100 MHz
    localparam int DEBOUNCE_CYCLES = 1000000;
    localparam int REPEAT_DELAY    = 50000000;
    localparam int REPEAT_PERIOD   = 10000000;

    // Bits needed for a counter that must reach the value 'cycles'
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button path: 2-flop synchroniser, debounce filter, press pulse and sticky flag.
// Macro BTN_REPEAT_EN adds a hold counter that re-fires the press pulse while the button stays down.
module btn_channel #(
    parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = btn_pkg::REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = btn_pkg::REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic sticky_clr,
    output logic level,
    output logic press,
    output logic sticky
);
    import btn_pkg::*;

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             stable_reg;
    logic             stable_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             press_reg;
    logic             press_next;
    logic             sticky_reg;
    logic             sticky_next;
    logic             rise;

    // Any sample that agrees with the accepted level restarts the stability count
    always_comb begin
        stable_next = stable_reg;
        cnt_next    = '0;
        if (sync_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    assign rise = stable_next & ~stable_reg;

`ifdef BTN_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_PERIOD);

    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;
    logic [HOLD_W-1:0] hold_inc;
    logic              repeating_reg;
    logic              repeating_next;
    logic              repeat_hit;

    // Counter restarts at each repeat; the target switches from the first delay to the period
    always_comb begin
        hold_inc       = hold_reg + 1'b1;
        hold_next      = '0;
        repeating_next = 1'b0;
        repeat_hit     = 1'b0;
        if (stable_reg && stable_next) begin
            repeating_next = repeating_reg;
            hold_next      = hold_inc;
            if (hold_inc == (repeating_reg ? HOLD_NEXT : HOLD_FIRST)) begin
                repeat_hit     = 1'b1;
                hold_next      = '0;
                repeating_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg      <= '0;
            repeating_reg <= 1'b0;
        end else begin
            hold_reg      <= hold_next;
            repeating_reg <= repeating_next;
        end
    end

    assign press_next = rise | repeat_hit;
`else
    assign press_next = rise;
`endif

    // Set beats clear when a press and a clear arrive together
    assign sticky_next = (sticky_reg & ~sticky_clr) | press_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            meta_reg   <= raw;
            sync_reg   <= meta_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
            press_reg  <= press_next;
            sticky_reg <= sticky_next;
        end
    end

    assign level  = stable_reg;
    assign press  = press_reg;
    assign sticky = sticky_reg;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end for the MMIO register file: N_BTN independent btn_channel instances.
// Define BTN_REPEAT_EN to enable auto-repeat press pulses on held buttons.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = btn_pkg::REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = btn_pkg::REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] sticky_clr,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_sticky
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .raw       (btn_raw[gi]),
                .sticky_clr(sticky_clr[gi]),
                .level     (btn_level[gi]),
                .press     (btn_press[gi]),
                .sticky    (btn_sticky[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus random stimulus against a cycle-history model.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int N    = 2;
    localparam int D    = 4;
    localparam int RD   = 10;
    localparam int RP   = 5;
    localparam int MAXC = 2000;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic [N-1:0] btn_raw    = '0;
    logic [N-1:0] sticky_clr = '0;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_sticky;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .sticky_clr(sticky_clr),
        .btn_level (btn_level),
        .btn_press (btn_press),
        .btn_sticky(btn_sticky)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Input history per cycle and the model's expected outputs per cycle
    logic [N-1:0] raw_h [MAXC];
    logic [N-1:0] clr_h [MAXC];
    bit           rst_h [MAXC];
    logic [N-1:0] lvl_m [MAXC];
    logic [N-1:0] prs_m [MAXC];
    logic [N-1:0] stk_m [MAXC];
    int           rise_m [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit rst_at(input int i);
        return (i < 0) ? 1'b1 : rst_h[i];
    endfunction

    // Synchronised pin value seen in cycle t: the raw pin two cycles earlier, zero near a reset
    function automatic logic sync_at(input int t, input int ch);
        if (t < 2 || rst_at(t - 1) || rst_at(t - 2)) return 1'b0;
        return raw_h[t - 2][ch];
    endfunction

    task automatic model(input int t);
        for (int ch = 0; ch < N; ch++) begin
            logic prev;
            logic lvl;
            logic prs;
            bit   flip;
            if (rst_at(t - 1)) begin
                lvl_m[t][ch] = 1'b0;
                prs_m[t][ch] = 1'b0;
                stk_m[t][ch] = 1'b0;
            end else begin
                prev = lvl_m[t - 1][ch];
                flip = 1'b1;
                for (int k = 1; k <= D; k++) begin
                    if (rst_at(t - k) || sync_at(t - k, ch) == prev) flip = 1'b0;
                end
                lvl = prev ^ flip;
                prs = 1'b0;
                if (lvl && !prev) begin
                    prs        = 1'b1;
                    rise_m[ch] = t;
                end
`ifdef BTN_REPEAT_EN
                else if (lvl && (t - rise_m[ch]) >= RD && ((t - rise_m[ch] - RD) % RP) == 0) begin
                    prs = 1'b1;
                end
`endif
                lvl_m[t][ch] = lvl;
                prs_m[t][ch] = prs;
                stk_m[t][ch] = (stk_m[t - 1][ch] & ~clr_h[t - 1][ch]) | prs_m[t - 1][ch];
            end
        end
    endtask

    // Drive one cycle of inputs, advance, then compare all outputs with the model
    task automatic step(input logic [N-1:0] raw, input logic [N-1:0] clr, input bit rst);
        if (cyc >= MAXC - 1) begin
            $display("FAIL history_overflow cycle=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "history overflow");
        end
        btn_raw    = raw;
        sticky_clr = clr;
        reset      = rst;
        raw_h[cyc] = raw;
        clr_h[cyc] = clr;
        rst_h[cyc] = rst;
        @(posedge clk);
        #1;
        cyc++;
        model(cyc);
        chk("level",  32'(btn_level),  32'(lvl_m[cyc]));
        chk("press",  32'(btn_press),  32'(prs_m[cyc]));
        chk("sticky", 32'(btn_sticky), 32'(stk_m[cyc]));
    endtask

    initial begin
        int           c0;
        int           fp;
        logic [N-1:0] seen;
        logic [N-1:0] rv;
        logic [N-1:0] cv;
        int           hold_left [N];
        int           pulses [$];
        int           exp_pulses [$];

        lvl_m[0] = '0;
        prs_m[0] = '0;
        stk_m[0] = '0;
        rv       = '0;
        for (int ch = 0; ch < N; ch++) begin
            rise_m[ch]    = 0;
            hold_left[ch] = 0;
        end

        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        chk("reset_outputs", 32'({btn_level, btn_press, btn_sticky}), 32'd0);
        repeat (3) step('0, '0, 1'b0);

        // Clean press on BTNU
        c0 = cyc;
        fp = -1;
        for (int i = 0; i < 12; i++) begin
            step(2'b01, '0, 1'b0);
            if (btn_press[BTN_IDX_U] && fp < 0) fp = cyc;
        end
        chk("clean_press_latency", 32'(fp - c0), 32'd6);
        chk("clean_level_held", 32'(btn_level[BTN_IDX_U]), 32'd1);
        repeat (12) step('0, '0, 1'b0);
        step('0, 2'b11, 1'b0);
        step('0, '0, 1'b0);
        chk("sticky_cleared", 32'(btn_sticky), 32'd0);

        // Clear coinciding with the press pulse, then clear one cycle later
        c0 = cyc;
        for (int i = 0; i < 14; i++) begin
            step(2'b01, (i == 6 || i == 7) ? 2'b01 : 2'b00, 1'b0);
            if (cyc == c0 + 7) chk("sticky_set_wins", 32'(btn_sticky[BTN_IDX_U]), 32'd1);
            if (cyc == c0 + 8) chk("sticky_clear_later", 32'(btn_sticky[BTN_IDX_U]), 32'd0);
        end
        repeat (14) step('0, '0, 1'b0);
        step('0, 2'b11, 1'b0);

        // Bounce: toggling every 2 cycles never survives the filter
        seen = '0;
        for (int i = 0; i < 32; i++) begin
            step((i < 20 && ((i >> 1) & 1) == 0) ? 2'b01 : 2'b00, '0, 1'b0);
            seen = seen | btn_level | btn_press | btn_sticky;
        end
        chk("bounce_quiet", 32'(seen[BTN_IDX_U]), 32'd0);

        // Reset pulsed while the button is held mid-count
        c0   = cyc;
        fp   = -1;
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            step(2'b01, '0, i == 4);
            if (btn_press[BTN_IDX_U]) begin
                if (cyc <= c0 + 10) seen[BTN_IDX_U] = 1'b1;
                else if (fp < 0) fp = cyc;
            end
        end
        chk("rst_no_early_press", 32'(seen[BTN_IDX_U]), 32'd0);
        chk("rst_press_after_release", 32'(fp - (c0 + 5)), 32'd6);
        repeat (14) step('0, '0, 1'b0);
        step('0, 2'b11, 1'b0);

        // Independence: both rise together, then only BTND releases
        c0 = cyc;
        fp = -1;
        for (int i = 0; i < 10; i++) begin
            step(2'b11, '0, 1'b0);
            if (btn_press != '0 && fp < 0) begin
                fp = cyc;
                chk("indep_both_press", 32'(btn_press), 32'd3);
            end
        end
        chk("indep_latency", 32'(fp - c0), 32'd6);
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            step(2'b01, '0, 1'b0);
            if (!btn_level[BTN_IDX_U]) seen[BTN_IDX_U] = 1'b1;
        end
        chk("indep_u_level_kept", 32'(seen[BTN_IDX_U]), 32'd0);
        chk("indep_d_level_fell", 32'(btn_level[BTN_IDX_D]), 32'd0);
        repeat (14) step('0, '0, 1'b0);
        step('0, 2'b11, 1'b0);

        // Long hold: 40 cycles down, then released
        c0 = cyc;
        for (int i = 0; i < 60; i++) begin
            step((i < 40) ? 2'b01 : 2'b00, '0, 1'b0);
            if (btn_press[BTN_IDX_U]) pulses.push_back(cyc - c0);
        end
`ifdef BTN_REPEAT_EN
        exp_pulses = '{6, 16, 21, 26, 31, 36, 41};
`else
        exp_pulses = '{6};
`endif
        chk("hold_pulse_count", 32'(pulses.size()), 32'(exp_pulses.size()));
        for (int i = 0; i < exp_pulses.size() && i < pulses.size(); i++) begin
            chk("hold_pulse_cycle", 32'(pulses[i]), 32'(exp_pulses[i]));
        end

        // Random hold lengths, random clears and occasional resets
        for (int i = 0; i < 500; i++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (hold_left[ch] == 0) begin
                    rv[ch]        = ~rv[ch];
                    hold_left[ch] = int'($urandom_range(1, 20));
                end
                hold_left[ch]--;
            end
            cv = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step(rv, cv, $urandom_range(0, 99) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
